// File: rtl/sw_run_controller.sv
// ---------------------------------------------------------------------------
// sw_run_controller
//
// Mode sequencer for the stopwatch datapath. Conditions the four raw
// push-buttons (synchroniser, optional debounce, rising-edge detect) and runs
// the IDLE/RUN/PAUSED/SPLIT state machine that drives the timer enable and
// clear, the lap-register load strobe and the display freeze select.
//
// Optional feature macro: SW_BTN_DEBOUNCE_EN
//   defined   : per-button debounce counters of DB_CYCLES clocks
//   undefined : filtered level is the synchroniser output directly
//
// Ports:
//   clk          system clock
//   clr          asynchronous active-low reset
//   tick         1-cycle once-per-second enable
//   start_btn    raw start button (async, active-high)
//   pause_btn    raw pause button (async, active-high)
//   lap_btn      raw lap/split button (async, active-high)
//   reset_btn    raw zero-request button (async, active-high)
//   run          timer count enable
//   timer_clr    1-cycle synchronous timer clear
//   lap_load     1-cycle lap register capture strobe
//   disp_freeze  1 = display shows lap register
//   lap_count    laps since last zero, saturating
//   state        IDLE=00, RUN=01, PAUSED=10, SPLIT=11
// ---------------------------------------------------------------------------
module sw_run_controller #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_TICKS  = 5,
    parameter int LAP_W       = 4,
    parameter int DB_CYCLES   = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             tick,
    input  logic             start_btn,
    input  logic             pause_btn,
    input  logic             lap_btn,
    input  logic             reset_btn,
    output logic             run,
    output logic             timer_clr,
    output logic             lap_load,
    output logic             disp_freeze,
    output logic [LAP_W-1:0] lap_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_SPLIT  = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        P_NONE,
        P_START,
        P_PAUSE,
        P_LAP,
        P_RESET
    } press_t;

    localparam int NBTN = 4;
    localparam logic [7:0] HOLD_VAL = 8'(HOLD_TICKS);

    // Elaboration-time parameter guard.
    if (SYNC_STAGES < 2 || HOLD_TICKS < 1 || HOLD_TICKS > 255 || DB_CYCLES < 1 || LAP_W < 1) begin : g_param_check
        $error("sw_run_controller: parameter out of range");
    end

    // Button index: 0 start, 1 pause, 2 lap, 3 reset.
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn_sync;
    logic [NBTN-1:0] btn_filt;
    logic [NBTN-1:0] btn_prev_reg;
    logic [NBTN-1:0] press_reg;

    assign btn_raw = {reset_btn, lap_btn, pause_btn, start_btn};

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            logic [SYNC_STAGES-1:0] sync_reg;

            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw[gi]};
                end
            end

            assign btn_sync[gi] = sync_reg[SYNC_STAGES-1];

`ifdef SW_BTN_DEBOUNCE_EN
            localparam int DBW = $clog2(DB_CYCLES + 1);
            localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
            logic [DBW-1:0] db_cnt_reg;
            logic           filt_reg;

            // Filtered level flips only after DB_CYCLES consecutive clocks of
            // disagreement; any agreement restarts the count.
            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    db_cnt_reg <= '0;
                    filt_reg   <= 1'b0;
                end else if (btn_sync[gi] != filt_reg) begin
                    if (db_cnt_reg == DB_LAST) begin
                        filt_reg   <= btn_sync[gi];
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end else begin
                    db_cnt_reg <= '0;
                end
            end

            assign btn_filt[gi] = filt_reg;
`else
            assign btn_filt[gi] = btn_sync[gi];
`endif

            // Edge flop resets to 0, so a button held through reset release
            // still produces exactly one press.
            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    btn_prev_reg[gi] <= 1'b0;
                    press_reg[gi]    <= 1'b0;
                end else begin
                    btn_prev_reg[gi] <= btn_filt[gi];
                    press_reg[gi]    <= btn_filt[gi] & ~btn_prev_reg[gi];
                end
            end
        end
    endgenerate

    // Priority encode: reset > start > pause > lap; the rest are dropped.
    press_t press;
    always_comb begin
        press = P_NONE;
        if (press_reg[3])      press = P_RESET;
        else if (press_reg[0]) press = P_START;
        else if (press_reg[1]) press = P_PAUSE;
        else if (press_reg[2]) press = P_LAP;
    end

    state_t           state_reg;
    logic             run_reg;
    logic             timer_clr_reg;
    logic             lap_load_reg;
    logic             freeze_reg;
    logic [LAP_W-1:0] lap_count_reg;
    logic [7:0]       hold_reg;
    logic [LAP_W-1:0] lap_count_inc;

    assign lap_count_inc = (lap_count_reg == '1) ? lap_count_reg : lap_count_reg + 1'b1;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg     <= ST_IDLE;
            run_reg       <= 1'b0;
            timer_clr_reg <= 1'b0;
            lap_load_reg  <= 1'b0;
            freeze_reg    <= 1'b0;
            lap_count_reg <= '0;
            hold_reg      <= '0;
        end else begin
            timer_clr_reg <= 1'b0;
            lap_load_reg  <= 1'b0;

            if (press == P_RESET) begin
                // Zero request is handled identically from every state.
                state_reg     <= ST_IDLE;
                run_reg       <= 1'b0;
                freeze_reg    <= 1'b0;
                timer_clr_reg <= 1'b1;
                lap_count_reg <= '0;
                hold_reg      <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (press == P_START) begin
                            state_reg <= ST_RUN;
                            run_reg   <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (press == P_PAUSE) begin
                            state_reg <= ST_PAUSED;
                            run_reg   <= 1'b0;
                        end else if (press == P_LAP) begin
                            state_reg     <= ST_SPLIT;
                            freeze_reg    <= 1'b1;
                            lap_load_reg  <= 1'b1;
                            lap_count_reg <= lap_count_inc;
                            hold_reg      <= HOLD_VAL;
                        end
                    end
                    ST_PAUSED: begin
                        if (press == P_START) begin
                            state_reg <= ST_RUN;
                            run_reg   <= 1'b1;
                        end
                    end
                    default: begin // ST_SPLIT
                        if (press == P_PAUSE) begin
                            state_reg  <= ST_PAUSED;
                            run_reg    <= 1'b0;
                            freeze_reg <= 1'b0;
                            hold_reg   <= '0;
                        end else if (press == P_LAP) begin
                            // Reload takes precedence over a same-cycle tick.
                            lap_load_reg  <= 1'b1;
                            lap_count_reg <= lap_count_inc;
                            hold_reg      <= HOLD_VAL;
                        end else if (tick) begin
                            if (hold_reg <= 8'd1) begin
                                state_reg  <= ST_RUN;
                                freeze_reg <= 1'b0;
                                hold_reg   <= '0;
                            end else begin
                                hold_reg <= hold_reg - 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign run         = run_reg;
    assign timer_clr   = timer_clr_reg;
    assign lap_load    = lap_load_reg;
    assign disp_freeze = freeze_reg;
    assign lap_count   = lap_count_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_sw_run_controller.sv
// ---------------------------------------------------------------------------
// tb_sw_run_controller
//
// Directed bench for sw_run_controller: a start-latency sequence, a table of
// button/tick transactions with hand-computed results, lap saturation, an
// asynchronous reset taken mid-SPLIT with a button held through release, and
// (with SW_BTN_DEBOUNCE_EN) a bouncing start button.
// ---------------------------------------------------------------------------
module tb_sw_run_controller;

    localparam int SYNC = 2;
`ifdef SW_BTN_DEBOUNCE_EN
    localparam int DB = 16;
`else
    localparam int DB = 0;
`endif
    localparam int LAT        = SYNC + 2 + DB;
    localparam int START_HOLD = (DB == 0) ? 3 : LAT;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       lap_btn = 1'b0;
    logic       reset_btn = 1'b0;
    logic       run;
    logic       timer_clr;
    logic       lap_load;
    logic       disp_freeze;
    logic [3:0] lap_count;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    sw_run_controller #(
        .SYNC_STAGES(SYNC),
        .HOLD_TICKS (5),
        .LAP_W      (4),
        .DB_CYCLES  (16)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .tick       (tick),
        .start_btn  (start_btn),
        .pause_btn  (pause_btn),
        .lap_btn    (lap_btn),
        .reset_btn  (reset_btn),
        .run        (run),
        .timer_clr  (timer_clr),
        .lap_load   (lap_load),
        .disp_freeze(disp_freeze),
        .lap_count  (lap_count),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Mask bits: [0] start, [1] pause, [2] lap, [3] reset.
    typedef struct {
        logic [3:0] mask;
        int         nticks;
        logic [1:0] st;
        logic       rn;
        logic       frz;
        logic [3:0] lc;
        int         ll;
        int         tc;
        bit         steady;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btns(input logic [3:0] m);
        start_btn = m[0];
        pause_btn = m[1];
        lap_btn   = m[2];
        reset_btn = m[3];
    endtask

    // Press the masked buttons, release, let the press settle, then issue
    // nticks tick pulses. Counts strobe-high cycles and run-low cycles.
    task automatic apply(input logic [3:0] m, input int nt,
                         output int ll, output int tc, output int rl);
        ll = 0; tc = 0; rl = 0;
        @(negedge clk);
        set_btns(m);
        repeat (LAT + 2) begin
            @(negedge clk);
            ll += int'(lap_load); tc += int'(timer_clr); rl += int'(!run);
        end
        set_btns(4'b0000);
        repeat (LAT + 4) begin
            @(negedge clk);
            ll += int'(lap_load); tc += int'(timer_clr); rl += int'(!run);
        end
        for (int t = 0; t < nt; t++) begin
            tick = 1'b1;
            @(negedge clk);
            ll += int'(lap_load); tc += int'(timer_clr); rl += int'(!run);
            tick = 1'b0;
            @(negedge clk);
            ll += int'(lap_load); tc += int'(timer_clr); rl += int'(!run);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ll, tc, rl, tot_ll;

        //            mask     nt st     rn    frz   lc    ll tc steady
        vecs[0]  = '{4'b0100, 0, 2'b11, 1'b1, 1'b1, 4'd1, 1, 0, 1'b1}; // RUN lap
        vecs[1]  = '{4'b0000, 5, 2'b01, 1'b1, 1'b0, 4'd1, 0, 0, 1'b1}; // 5 ticks end split
        vecs[2]  = '{4'b0100, 2, 2'b11, 1'b1, 1'b1, 4'd2, 1, 0, 1'b1}; // lap, 2 ticks
        vecs[3]  = '{4'b0100, 4, 2'b11, 1'b1, 1'b1, 4'd3, 1, 0, 1'b1}; // reload, 4 ticks
        vecs[4]  = '{4'b0000, 1, 2'b01, 1'b1, 1'b0, 4'd3, 0, 0, 1'b1}; // 5th tick exits
        vecs[5]  = '{4'b0100, 0, 2'b11, 1'b1, 1'b1, 4'd4, 1, 0, 1'b0};
        vecs[6]  = '{4'b0010, 0, 2'b10, 1'b0, 1'b0, 4'd4, 0, 0, 1'b0}; // pause from SPLIT
        vecs[7]  = '{4'b0000, 3, 2'b10, 1'b0, 1'b0, 4'd4, 0, 0, 1'b0}; // ticks ignored
        vecs[8]  = '{4'b0100, 0, 2'b10, 1'b0, 1'b0, 4'd4, 0, 0, 1'b0}; // lap ignored
        vecs[9]  = '{4'b0010, 0, 2'b10, 1'b0, 1'b0, 4'd4, 0, 0, 1'b0}; // pause ignored
        vecs[10] = '{4'b1001, 0, 2'b00, 1'b0, 1'b0, 4'd0, 0, 1, 1'b0}; // start+reset
        vecs[11] = '{4'b1000, 0, 2'b00, 1'b0, 1'b0, 4'd0, 0, 1, 1'b0}; // reset in IDLE
        vecs[12] = '{4'b0110, 0, 2'b00, 1'b0, 1'b0, 4'd0, 0, 0, 1'b0}; // pause+lap ignored
        vecs[13] = '{4'b0000, 3, 2'b00, 1'b0, 1'b0, 4'd0, 0, 0, 1'b0};
        vecs[14] = '{4'b0001, 0, 2'b01, 1'b1, 1'b0, 4'd0, 0, 0, 1'b0};
        vecs[15] = '{4'b0110, 0, 2'b10, 1'b0, 1'b0, 4'd0, 0, 0, 1'b0}; // pause+lap in RUN
        vecs[16] = '{4'b0001, 0, 2'b01, 1'b1, 1'b0, 4'd0, 0, 0, 1'b0};
        vecs[17] = '{4'b0100, 0, 2'b11, 1'b1, 1'b1, 4'd1, 1, 0, 1'b1};
        vecs[18] = '{4'b0001, 2, 2'b11, 1'b1, 1'b1, 4'd1, 0, 0, 1'b1}; // start ignored
        vecs[19] = '{4'b0000, 3, 2'b01, 1'b1, 1'b0, 4'd1, 0, 0, 1'b1};
        vecs[20] = '{4'b1000, 0, 2'b00, 1'b0, 1'b0, 4'd0, 0, 1, 1'b0}; // reset from RUN

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_run", int'(run), 0);
        chk("reset_lap_count", int'(lap_count), 0);
        chk("reset_strobes", int'({timer_clr, lap_load, disp_freeze}), 0);
        clr = 1'b1;
        repeat (2) @(negedge clk);

        // Start latency: button first sampled at edge 1, RUN after edge LAT.
        start_btn = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == START_HOLD) start_btn = 1'b0;
            if (k == LAT - 1) chk("start_latency_early", int'(state), 0);
        end
        chk("start_state", int'(state), 1);
        chk("start_run", int'(run), 1);
        chk("start_timer_clr", int'(timer_clr), 0);
        chk("start_lap_count", int'(lap_count), 0);
        repeat (LAT + 4) @(negedge clk);
        chk("start_single", int'(state), 1);
        $display("start seq: state=%0d run=%0d lap_count=%0d", state, run, lap_count);

        // Table-driven transactions
        for (int i = 0; i < 21; i++) begin
            apply(vecs[i].mask, vecs[i].nticks, ll, tc, rl);
            $display("vec %0d: mask=%b ticks=%0d -> state=%0d run=%0d frz=%0d lc=%0d lap_loads=%0d clrs=%0d",
                     i, vecs[i].mask, vecs[i].nticks, state, run, disp_freeze, lap_count, ll, tc);
            chk($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].st));
            chk($sformatf("vec%0d_run", i), int'(run), int'(vecs[i].rn));
            chk($sformatf("vec%0d_freeze", i), int'(disp_freeze), int'(vecs[i].frz));
            chk($sformatf("vec%0d_lap_count", i), int'(lap_count), int'(vecs[i].lc));
            chk($sformatf("vec%0d_lap_load_cycles", i), ll, vecs[i].ll);
            chk($sformatf("vec%0d_timer_clr_cycles", i), tc, vecs[i].tc);
            if (vecs[i].steady) chk($sformatf("vec%0d_run_low_cycles", i), rl, 0);
        end

        // Lap counter saturation: 17 laps from RUN
        apply(4'b0001, 0, ll, tc, rl);
        chk("sat_start_state", int'(state), 1);
        tot_ll = 0;
        for (int i = 0; i < 17; i++) begin
            apply(4'b0100, 0, ll, tc, rl);
            tot_ll += ll;
            $display("sat lap %0d: lap_count=%0d lap_load_cycles=%0d", i + 1, lap_count, ll);
            chk($sformatf("sat_lap%0d_count", i + 1), int'(lap_count), (i + 1 > 15) ? 15 : i + 1);
        end
        chk("sat_total_lap_loads", tot_ll, 17);
        chk("sat_state_split", int'(state), 3);

        // Async reset mid-SPLIT, with reset_btn held through release
        @(negedge clk);
        #2;
        clr = 1'b0;
        reset_btn = 1'b1;
        #1;
        chk("async_clr_state", int'(state), 0);
        chk("async_clr_run", int'(run), 0);
        chk("async_clr_freeze", int'(disp_freeze), 0);
        chk("async_clr_lap_count", int'(lap_count), 0);
        chk("async_clr_strobes", int'({timer_clr, lap_load}), 0);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        tc = 0;
        repeat (3 * LAT) begin
            @(negedge clk);
            tc += int'(timer_clr);
        end
        $display("held reset_btn through clr release: timer_clr cycles=%0d state=%0d", tc, state);
        chk("held_btn_single_press", tc, 1);
        chk("held_btn_state", int'(state), 0);
        reset_btn = 1'b0;
        repeat (LAT + 4) @(negedge clk);

`ifdef SW_BTN_DEBOUNCE_EN
        // Bouncing start button, then stable high
        for (int b = 0; b < 4; b++) begin
            start_btn = 1'b1;
            repeat (5) @(negedge clk);
            start_btn = 1'b0;
            repeat (5) @(negedge clk);
        end
        chk("bounce_no_run", int'(state), 0);
        start_btn = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == LAT - 1) chk("bounce_latency_early", int'(state), 0);
        end
        chk("bounce_run", int'(state), 1);
        $display("bounce seq: state=%0d", state);
        start_btn = 1'b0;
        repeat (LAT + 4) @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
